// File: rtl/west_feeder_pkg.sv
// Shared encodings for the west-edge feeder of the systolic array.
// Holds the per-row instruction codes and the sequencer state encoding.
package west_feeder_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/west_feeder_skew_line.sv
// Reset-clearable shift register used as the per-row skew delay.
// Data and instruction bits of a row share one word so they never split.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/west_feeder.sv
// West-edge feeder: load/execute sequencer plus per-row skew lines.
// Optional stall counter output enabled by defining WEST_FEEDER_PERF_EN.
module west_feeder
    import west_feeder_pkg::*;
#(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_vec,
    input  logic [row*bw-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [row*bw-1:0] out_w,
    output logic [2*row-1:0]  inst_w,
`ifdef WEST_FEEDER_PERF_EN
    output logic [15:0]       perf_stall,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] COL_LAST = 8'(col - 1);
    localparam logic [7:0] ROW_LAST = 8'(row - 1);

    state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] nv_q, nv_d;
    logic hs;
    logic [1:0] inj_inst;
    logic [row*bw-1:0] inj_data;

    assign in_ready = (state_q == ST_LOAD) || (state_q == ST_EXEC);
    assign hs       = in_valid & in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    // One counter serves load, exec and drain; it restarts at each phase.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nv_d     = nv_q;
        inj_inst = INST_IDLE;
        inj_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    nv_d    = num_vec;
                    cnt_d   = 8'd0;
                end
            end
            ST_LOAD: begin
                if (hs) begin
                    inj_inst = INST_LOAD;
                    inj_data = in_data;
                    if (cnt_q == COL_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = (nv_q == 8'd0) ? ST_DRAIN : ST_EXEC;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_EXEC: begin
                if (hs) begin
                    inj_inst = INST_EXEC;
                    inj_data = in_data;
                    if (cnt_q == nv_q - 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == ROW_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            nv_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nv_q    <= nv_d;
        end
    end

`ifdef WEST_FEEDER_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && start) begin
            perf_d = 16'd0;
        end else if (in_ready && !hs) begin
            perf_d = sat_inc16(perf_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 16'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`endif

    for (genvar r = 0; r < row; r++) begin : g_row
        logic [bw+1:0] q;

        skew_line #(
            .DEPTH(r + 1),
            .WIDTH(bw + 2)
        ) u_skew (
            .clk  (clk),
            .reset(reset),
            .d    ({inj_inst, inj_data[r*bw +: bw]}),
            .q    (q)
        );

        assign out_w[r*bw +: bw] = q[bw-1:0];
        assign inst_w[2*r +: 2]  = q[bw+1:bw];
    end

endmodule

// File: tb/tb_west_feeder.sv
// Self-checking bench for west_feeder against a phase-level timeline model.
// Define WEST_FEEDER_PERF_EN to also check the stall counter.
module tb_west_feeder;

    localparam int BW   = 4;
    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int MAXC = 200;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [7:0] num_vec;
    logic [ROW*BW-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [ROW*BW-1:0] out_w;
    logic [2*ROW-1:0] inst_w;
    logic busy;
    logic done;
`ifdef WEST_FEEDER_PERF_EN
    logic [15:0] perf_stall;
`endif

    always #5 clk = ~clk;

    west_feeder #(.bw(BW), .row(ROW), .col(COL)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_w     (out_w),
        .inst_w    (inst_w),
`ifdef WEST_FEEDER_PERF_EN
        .perf_stall(perf_stall),
`endif
        .busy      (busy),
        .done      (done)
    );

    int nchk = 0;
    int nerr = 0;

    logic              vpat  [MAXC];
    logic [ROW*BW-1:0] dpat  [MAXC];
    logic [ROW*BW-1:0] inj_d [MAXC];
    logic [1:0]        inj_i [MAXC];
    logic              rdy_e [MAXC];
    logic              busy_e[MAXC];
    int                done_cyc;
    int                bubbles;

    // Timeline: col accepted loads, nv accepted execs, row drain cycles, done.
    task automatic build_model(input int nv);
        int c;
        int n;
        for (int i = 0; i < MAXC; i++) begin
            inj_d[i] = '0; inj_i[i] = 2'b00;
            rdy_e[i] = 1'b0; busy_e[i] = 1'b0;
        end
        bubbles = 0;
        c = 1;
        n = 0;
        while (n < COL) begin
            rdy_e[c] = 1'b1; busy_e[c] = 1'b1;
            if (vpat[c]) begin
                inj_i[c] = 2'b01; inj_d[c] = dpat[c]; n++;
            end else bubbles++;
            c++;
        end
        n = 0;
        while (n < nv) begin
            rdy_e[c] = 1'b1; busy_e[c] = 1'b1;
            if (vpat[c]) begin
                inj_i[c] = 2'b10; inj_d[c] = dpat[c]; n++;
            end else bubbles++;
            c++;
        end
        for (int k = 0; k < ROW; k++) begin
            busy_e[c] = 1'b1; c++;
        end
        busy_e[c] = 1'b1;
        done_cyc = c;
    endtask

    task automatic fill_pattern(input bit all_valid, input int hole);
        for (int i = 0; i < MAXC; i++) begin
            dpat[i] = {$urandom, $urandom};
            if (all_valid) vpat[i] = (i != hole);
            else vpat[i] = ($urandom_range(3) != 0) || (i > 60);
        end
    endtask

    // Runs one sequence starting at local cycle 0 and checks every cycle.
    task automatic run_seq(input int nv, input int xs_cyc,
                           input int rst_cyc, input int exp_done);
        int ncyc;
        int obs_done;
        int src;
        logic [ROW*BW-1:0] eo;
        logic [2*ROW-1:0] ei;
        build_model(nv);
        ncyc = (rst_cyc >= 0) ? rst_cyc + 1 : done_cyc + 2;
        obs_done = -1;
        for (int c = 0; c < ncyc; c++) begin
            reset    = (c == rst_cyc);
            start    = (c == 0) || (c == xs_cyc);
            num_vec  = (c == 0) ? 8'(nv) : 8'($urandom_range(255));
            in_valid = vpat[c];
            in_data  = dpat[c];
            @(negedge clk);
            eo = '0;
            ei = '0;
            for (int r = 0; r < ROW; r++) begin
                src = c - 1 - r;
                if (src >= 0) begin
                    eo[r*BW +: BW] = inj_d[src][r*BW +: BW];
                    ei[2*r +: 2]   = inj_i[src];
                end
            end
            nchk++;
            if (out_w !== eo) begin
                nerr++;
                $display("FAIL out_w cyc=%0d got=%h want=%h", c, out_w, eo);
            end
            nchk++;
            if (inst_w !== ei) begin
                nerr++;
                $display("FAIL inst_w cyc=%0d got=%h want=%h", c, inst_w, ei);
            end
            nchk++;
            if (in_ready !== rdy_e[c]) begin
                nerr++;
                $display("FAIL in_ready cyc=%0d got=%b want=%b", c, in_ready, rdy_e[c]);
            end
            nchk++;
            if (busy !== busy_e[c]) begin
                nerr++;
                $display("FAIL busy cyc=%0d got=%b want=%b", c, busy, busy_e[c]);
            end
            nchk++;
            if (done !== (c == done_cyc)) begin
                nerr++;
                $display("FAIL done cyc=%0d got=%b want=%b", c, done, (c == done_cyc));
            end
            if (done === 1'b1 && obs_done < 0) obs_done = c;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        start = 1'b0;
        if (exp_done >= 0) begin
            nchk++;
            if (obs_done != exp_done) begin
                nerr++;
                $display("FAIL done_cycle got=%0d want=%0d", obs_done, exp_done);
            end
        end
`ifdef WEST_FEEDER_PERF_EN
        if (rst_cyc < 0) begin
            nchk++;
            if (perf_stall !== 16'(bubbles)) begin
                nerr++;
                $display("FAIL perf_stall got=%0d want=%0d", perf_stall, bubbles);
            end
        end
`endif
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        num_vec  = 8'd3;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            nchk++;
            if (out_w !== '0 || inst_w !== '0 || busy !== 1'b0 ||
                in_ready !== 1'b0 || done !== 1'b0) begin
                nerr++;
                $display("FAIL reset_state cyc=%0d got=%h/%h/%b%b%b want=0",
                         i, out_w, inst_w, busy, in_ready, done);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        fill_pattern(1'b1, -1);
        run_seq(4, -1, -1, 21);
    endtask

    task automatic test_stall();
        fill_pattern(1'b1, 3);
        run_seq(4, -1, -1, 22);
    endtask

    task automatic test_zero_exec();
        fill_pattern(1'b1, -1);
        run_seq(0, -1, -1, 17);
    endtask

    task automatic test_reset_mid();
        fill_pattern(1'b1, -1);
        run_seq(4, -1, 11, -1);
        fill_pattern(1'b1, -1);
        run_seq(4, -1, -1, 21);
    endtask

    task automatic test_start_while_busy();
        fill_pattern(1'b1, -1);
        run_seq(4, 5, -1, 21);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            fill_pattern(1'b0, -1);
            run_seq(int'($urandom_range(6)), int'($urandom_range(3, 9)), -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_exec();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/west_feeder.md
WEST_FEEDER -- requirements
Module: west_feeder

Interface
REQ-001 Parameter bw, 4, activation/weight element width per row.
REQ-002 Parameter row, 8, number of array rows driven.
REQ-003 Parameter col, 8, number of kernel vectors per load phase (1..255).
REQ-004 Clock clk; reset reset, synchronous, active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to begin a load+execute sequence.
REQ-008 num_vec  input  8  execute vector count, sampled when start is accepted.
REQ-009 in_data  input  row*bw  one element per row; row r at bits [r*bw +: bw].
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  feeder accepts in_data this cycle.
REQ-012 out_w  output  row*bw  skewed west data to array; row r at [r*bw +: bw].
REQ-013 inst_w  output  2*row  skewed west instruction; row r at [2r +: 2]; bit1 execute, bit0 kernel load.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  single-cycle pulse at sequence end.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, EXEC, DRAIN, DONE.
REQ-017 IDLE: in_ready=0; start=1 -> LOAD next cycle, num_vec latched; start in any other state ignored.
REQ-018 LOAD: in_ready=1; each handshake (in_valid&in_ready) injects in_data with inst 01; after col-th handshake -> EXEC, or -> DRAIN if latched num_vec==0.
REQ-019 EXEC: in_ready=1; each handshake injects in_data with inst 10; after num_vec-th handshake -> DRAIN.
REQ-020 Any LOAD/EXEC cycle without handshake SHALL inject a bubble: data 0, inst 00; counters unchanged.
REQ-021 DRAIN: in_ready=0, injects bubbles for exactly row cycles, then -> DONE.
REQ-022 DONE: done=1 for one cycle, in_ready=0, -> IDLE; no injection.
REQ-023 Skew: element/inst injected at cycle t SHALL appear on row r outputs at cycle t+1+r (row 0 registered once, each further row one extra stage).
REQ-024 Data and inst of a row SHALL always travel in the same pipeline stage; never split.
REQ-025 Load/exec counters 8 bits, compare by equality; no wrap within a sequence.

Reset
REQ-026 On reset: state IDLE, all skew stages 0, counters 0; out_w=0, inst_w=0, in_ready=0, busy=0, done=0 from the next cycle.
REQ-027 Reset mid-sequence SHALL abort it with no done pulse; start accepted the cycle after reset deasserts.

Configuration
REQ-028 With WEST_FEEDER_PERF_EN defined: extra output perf_stall (16 bits), counts LOAD/EXEC bubble cycles, cleared on reset and on accepted start, saturates at 0xFFFF.
REQ-029 Without WEST_FEEDER_PERF_EN: port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold inst encodings (INST_IDLE=00, INST_LOAD=01, INST_EXEC=10) and the FSM state encoding.
REQ-031 Sub-module skew_line (parameterised depth and width, reset-clearable shift register) SHALL implement each row delay; west_feeder instantiates row of them.

Verification (row=8, col=8, bw=4; start at cycle 0)
REQ-032 Reset held 3 cycles with in_valid=1 -> out_w=0, inst_w=0, busy=0, in_ready=0 throughout.
REQ-033 num_vec=4, in_valid always 1 -> row0 inst 01 cycles 2..9, 10 cycles 10..13; row7 inst 01 cycles 9..16, 10 cycles 17..20; done=1 at cycle 21 only.
REQ-034 Same, in_valid=0 at cycle 3 -> row0 inst 00/data 0 at cycle 4, still 8 loads and 4 execs, done at 22; perf_stall=1 with macro.
REQ-035 num_vec=0 -> 8 loads then DRAIN; inst 10 never appears on any row; done at cycle 17.
REQ-036 Reset at cycle 11 during EXEC -> cycle 12 all outputs 0, no done; new start at 12 runs full sequence correctly.
REQ-037 start pulsed at cycle 5 while busy -> ignored; num_vec change not observed; timing identical to REQ-033.
